key_irq_ctrl: RTL and testbench

Collects the single-cycle debounced key pulses produced by the per-key filter stages and turns them into an 8088-compatible maskable interrupt. It provides the following:
- a latched pending register per key;
- a mask register and an in-service register;
- a fixed-priority arbiter;
- an INTA two-cycle handshake that returns an 8-bit vector.

It sits between the key filters and the CPU interrupt pin and bus decoder.

---
 rtl/key_irq_pkg.sv | 16 +
 rtl/key_irq_ctrl_if.sv | 25 ++
 rtl/key_irq_prio.sv | 20 ++
 rtl/key_irq_ctrl.sv | 140 ++++++++++++++
 tb/tb_key_irq_ctrl.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/key_irq_pkg.sv
// key_irq_pkg: shared types and constants for the key interrupt controller.
package key_irq_pkg;

  localparam int MAX_KEYS  = 8;
  localparam int KEY_IDX_W = 3;

  localparam logic ADDR_PEND_MASK = 1'b0;
  localparam logic ADDR_ISR_EOI   = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_ACK1 = 2'd2
  } state_e;

endpackage

// File: rtl/key_irq_ctrl_if.sv
// key_irq_ctrl_if: CPU register bus and INTA handshake of the
// key interrupt controller.
interface key_irq_ctrl_if;

  logic       cs;
  logic       rd;
  logic       wr;
  logic       addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       inta;
  logic       irq;
  logic [7:0] int_vec;

  modport master (
    output cs, rd, wr, addr, wdata, inta,
    input  rdata, irq, int_vec
  );

  modport slave (
    input  cs, rd, wr, addr, wdata, inta,
    output rdata, irq, int_vec
  );

endinterface

// File: rtl/key_irq_prio.sv
// key_irq_prio: combinational lowest-index-wins priority encoder.
module key_irq_prio
  import key_irq_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]           req,
  output logic                   valid,
  output logic [KEY_IDX_W-1:0]   idx
);

  always_comb begin
    valid = |req;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = KEY_IDX_W'(i);
    end
  end

endmodule

// File: rtl/key_irq_ctrl.sv
// key_irq_ctrl: key pulses to 8088-style maskable interrupt with INTA vector.
// Define KEY_IRQ_AUTO_EOI_EN to drop the in-service register (auto EOI).
module key_irq_ctrl
  import key_irq_pkg::*;
#(
  parameter int         NUM_KEYS    = 4,
  parameter logic [7:0] VECTOR_BASE = 8'h40
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic [NUM_KEYS-1:0] key_flag,
  key_irq_ctrl_if.slave       bus
);

  state_e                state;
  logic [NUM_KEYS-1:0]   pending;
  logic [NUM_KEYS-1:0]   mask;
  logic [NUM_KEYS-1:0]   in_service;
  logic [NUM_KEYS-1:0]   eligible;
  logic [NUM_KEYS-1:0]   sel_oh;
  logic [KEY_IDX_W-1:0]  sel;
  logic [KEY_IDX_W-1:0]  win_idx;
  logic                  win_vld;
  logic                  spur_ph;
  logic                  ack;
  logic                  rd_en;
  logic                  wr_en;
  logic [7:0]            rd_val;
  logic [7:0]            rdata_q;
  logic [7:0]            vec_q;
  logic                  irq_q;
  logic                  unused_wdata;

  assign rd_en    = bus.cs & bus.rd;
  assign wr_en    = bus.cs & bus.wr;
  assign eligible = pending & ~mask;
  assign ack      = (state == ST_ACK1) & bus.inta;

  assign bus.rdata   = rdata_q;
  assign bus.irq     = irq_q;
  assign bus.int_vec = vec_q;
  assign unused_wdata = ^bus.wdata;

  key_irq_prio #(
    .N (NUM_KEYS)
  ) u_prio (
    .req   (eligible),
    .valid (win_vld),
    .idx   (win_idx)
  );

  always_comb begin
    sel_oh = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      sel_oh[i] = (sel == KEY_IDX_W'(i));
    end
  end

  always_comb begin
    rd_val = 8'(pending);
    if (bus.addr == ADDR_ISR_EOI) rd_val = 8'(in_service);
  end

  // A fresh press in the ack cycle wins over the clear.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      pending <= '0;
      mask    <= '1;
      rdata_q <= '0;
    end else begin
      pending <= (pending & ~(ack ? sel_oh : '0)) | key_flag;
      if (wr_en && bus.addr == ADDR_PEND_MASK)
        mask <= bus.wdata[NUM_KEYS-1:0];
      if (rd_en)
        rdata_q <= rd_val;
    end
  end

`ifdef KEY_IRQ_AUTO_EOI_EN
  assign in_service = '0;
`else
  logic eoi;
  assign eoi = wr_en & (bus.addr == ADDR_ISR_EOI);

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      in_service <= '0;
    end else begin
      in_service <= (eoi ? '0 : in_service)
                  | (ack ? sel_oh : '0);
    end
  end
`endif

  // spur_ph pairs INTA cycles seen while no request is outstanding.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state   <= ST_IDLE;
      sel     <= '0;
      spur_ph <= 1'b0;
      irq_q   <= 1'b0;
      vec_q   <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (bus.inta) begin
            if (spur_ph)
              vec_q <= VECTOR_BASE + 8'(NUM_KEYS);
            spur_ph <= ~spur_ph;
          end else if (win_vld && in_service == '0
                       && !spur_ph) begin
            state <= ST_REQ;
            irq_q <= 1'b1;
          end
        end
        ST_REQ: begin
          if (!win_vld) begin
            state <= ST_IDLE;
            irq_q <= 1'b0;
          end else if (bus.inta) begin
            sel   <= win_idx;
            state <= ST_ACK1;
          end
        end
        ST_ACK1: begin
          if (bus.inta) begin
            vec_q <= VECTOR_BASE + 8'(sel);
            irq_q <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
          irq_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_irq_ctrl.sv
// tb_key_irq_ctrl: directed stimulus with queued expectations
// checked by an independent monitor on the falling edge.
module tb_key_irq_ctrl;

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic [3:0] key_flag  = '0;
  logic       vec_chk   = 1'b0;
  logic       irq_chk   = 1'b0;
  logic       pend_rd   = 1'b0;
  logic       pend_vec  = 1'b0;

  logic [7:0] q_rd[$];
  logic [7:0] q_vec[$];
  logic       q_irq[$];

  int n_pass = 0;
  int n_tot  = 0;

  key_irq_ctrl_if bus ();

  key_irq_ctrl #(
    .NUM_KEYS    (4),
    .VECTOR_BASE (8'h40)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .key_flag  (key_flag),
    .bus       (bus)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name,
                       input logic [7:0] act,
                       input logic [7:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  always @(negedge sys_clk) begin
    if (pend_rd) begin
      if (q_rd.size() == 0) begin
        n_tot++;
        $display("FAIL rdata: unexpected read");
      end else check("rdata", bus.rdata, q_rd.pop_front());
    end
    if (pend_vec) begin
      if (q_vec.size() == 0) begin
        n_tot++;
        $display("FAIL int_vec: no expectation");
      end else check("int_vec", bus.int_vec, q_vec.pop_front());
    end
    if (irq_chk) begin
      if (q_irq.size() == 0) begin
        n_tot++;
        $display("FAIL irq: no expectation");
      end else check("irq", {7'b0, bus.irq}, {7'b0, q_irq.pop_front()});
    end
    pend_rd  = bus.cs & bus.rd;
    pend_vec = vec_chk;
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
    bus.cs    = 1'b0;
    bus.rd    = 1'b0;
    bus.wr    = 1'b0;
    bus.addr  = 1'b0;
    bus.wdata = '0;
    bus.inta  = 1'b0;
    key_flag  = '0;
    vec_chk   = 1'b0;
    irq_chk   = 1'b0;
  endtask

  task automatic exp_irq(input logic e);
    q_irq.push_back(e);
    irq_chk = 1'b1;
  endtask

  task automatic rd_reg(input logic a, input logic [7:0] e);
    bus.cs   = 1'b1;
    bus.rd   = 1'b1;
    bus.addr = a;
    q_rd.push_back(e);
    tick();
  endtask

  task automatic wr_reg(input logic a, input logic [7:0] d);
    bus.cs    = 1'b1;
    bus.wr    = 1'b1;
    bus.addr  = a;
    bus.wdata = d;
    tick();
  endtask

  task automatic key(input int k);
    key_flag[k] = 1'b1;
    tick();
  endtask

  task automatic inta1();
    bus.inta = 1'b1;
    tick();
  endtask

  task automatic inta2(input logic [7:0] v);
    bus.inta = 1'b1;
    vec_chk  = 1'b1;
    q_vec.push_back(v);
    tick();
  endtask

  task automatic handshake(input logic [7:0] v);
    inta1();
    exp_irq(1'b1);
    tick();
    inta2(v);
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    tick();
    sys_rst_n = 1'b1;
  endtask

  initial begin
    bus.cs = 1'b0; bus.rd = 1'b0; bus.wr = 1'b0;
    bus.addr = 1'b0; bus.wdata = '0; bus.inta = 1'b0;
    tick();
    tick();
    sys_rst_n = 1'b1;

    // reset state
    exp_irq(1'b0);
    vec_chk = 1'b1;
    q_vec.push_back(8'h00);
    rd_reg(1'b0, 8'h00);
    rd_reg(1'b1, 8'h00);

    // reset mask is all-ones: press is latched but no irq
    key(1);
    exp_irq(1'b0); tick();
    exp_irq(1'b0); tick();
    rd_reg(1'b0, 8'h02);
    do_reset();
    rd_reg(1'b0, 8'h00);

    // single key 2
    wr_reg(1'b0, 8'h00);
    key(2);
    exp_irq(1'b0); rd_reg(1'b0, 8'h04);
    exp_irq(1'b1); tick();
    handshake(8'h42);
    exp_irq(1'b0); rd_reg(1'b0, 8'h00);
    rd_reg(1'b1, 8'h04);

    // in service blocks a new request until EOI
    key(0);
    tick();
    exp_irq(1'b0); tick();
    exp_irq(1'b0); tick();
    wr_reg(1'b1, 8'hA5);
    exp_irq(1'b0); rd_reg(1'b1, 8'h00);
    exp_irq(1'b1); tick();
    handshake(8'h40);
    wr_reg(1'b1, 8'h00);
    tick();

    // keys 1 and 3 together
    key_flag = 4'b1010;
    tick();
    tick();
    exp_irq(1'b1); tick();
    handshake(8'h41);
    exp_irq(1'b0); rd_reg(1'b0, 8'h08);
    rd_reg(1'b1, 8'h02);
    wr_reg(1'b1, 8'h00);
    exp_irq(1'b0); tick();
    exp_irq(1'b1); tick();
    handshake(8'h43);
    wr_reg(1'b1, 8'h00);
    tick();
    rd_reg(1'b0, 8'h00);

    // mask write withdraws a raised request
    key(0);
    tick();
    exp_irq(1'b1); wr_reg(1'b0, 8'h01);
    tick();
    exp_irq(1'b0); rd_reg(1'b0, 8'h01);

    // press coincident with its own acknowledge
    wr_reg(1'b0, 8'h00);
    tick();
    exp_irq(1'b1); inta1();
    tick();
    key_flag = 4'b0001;
    inta2(8'h40);
    exp_irq(1'b0); rd_reg(1'b0, 8'h01);
    rd_reg(1'b1, 8'h01);
    wr_reg(1'b1, 8'h00);
    exp_irq(1'b0); tick();
    exp_irq(1'b1); tick();
    handshake(8'h40);
    wr_reg(1'b1, 8'h00);
    tick();
    rd_reg(1'b0, 8'h00);

    // spurious INTA pair
    exp_irq(1'b0); inta1();
    exp_irq(1'b0); tick();
    inta2(8'h44);
    exp_irq(1'b0); rd_reg(1'b0, 8'h00);
    rd_reg(1'b1, 8'h00);
    key(3);
    tick();
    exp_irq(1'b1); handshake(8'h43);
    wr_reg(1'b1, 8'h00);
    tick();

    // reset in the middle of a handshake
    key(2);
    tick();
    exp_irq(1'b1); inta1();
    tick();
    do_reset();
    exp_irq(1'b0); rd_reg(1'b0, 8'h00);
    rd_reg(1'b1, 8'h00);
    inta1();
    tick();
    inta2(8'h44);
    exp_irq(1'b0); tick();
    tick();
    tick();

    n_tot++;
    if (q_rd.size() == 0 && q_vec.size() == 0 && q_irq.size() == 0)
      n_pass++;
    else
      $display("FAIL drain: rd=%0d vec=%0d irq=%0d left",
               q_rd.size(), q_vec.size(), q_irq.size());

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
